// File: rtl/univ_shift_reg.sv
`default_nettype none
// =============================================================================
// univ_shift_reg : WIDTH-bit universal register, 8 ops, sequenced multi-step shift
// Revision: 1.0
// =============================================================================
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter int               AMT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_ASR   = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  logic [2:0]       w_step_op;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_sout;
  logic             w_seq_op;

  // While sequencing, the latched op drives the datapath; live op is ignored.
  assign w_step_op = (state_q == S_SHIFT) ? op_q : op;
  assign w_seq_op  = (op >= OP_SHL) && (op <= OP_ASR);

  always_comb begin
    w_step_q    = q_q;
    w_step_sout = sout_q;
    case (w_step_op)
      OP_LOAD:  w_step_q = d;
      OP_SHL: begin
        w_step_q    = {q_q[WIDTH-2:0], sin};
        w_step_sout = q_q[WIDTH-1];
      end
      OP_SHR: begin
        w_step_q    = {sin, q_q[WIDTH-1:1]};
        w_step_sout = q_q[0];
      end
      OP_ROL: begin
        w_step_q    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        w_step_sout = q_q[WIDTH-1];
      end
      OP_ROR: begin
        w_step_q    = {q_q[0], q_q[WIDTH-1:1]};
        w_step_sout = q_q[0];
      end
      OP_ASR: begin
        w_step_q    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        w_step_sout = q_q[0];
      end
      OP_CLEAR: w_step_q = '0;
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = 1'b0;
    if (en) begin
      if (state_q == S_SHIFT) begin
        q_d    = w_step_q;
        sout_d = w_step_sout;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end else if (start && w_seq_op && (amt != '0)) begin
        q_d    = w_step_q;
        sout_d = w_step_sout;
        op_d   = op;
        if (amt == AMT_W'(1)) begin
          done_d = 1'b1;
        end else begin
          state_d = S_SHIFT;
          cnt_d   = amt - AMT_W'(1);
        end
      end else if (start && w_seq_op) begin
        // Zero-length shift degenerates to HOLD but still handshakes.
        done_d = 1'b1;
      end else begin
        q_d    = w_step_q;
        sout_d = w_step_sout;
        done_d = start;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      q_q     <= RESET_VAL;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == S_SHIFT);
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// =============================================================================
// tb_univ_shift_reg : randomized + directed checks against an arithmetic model
// Revision: 1.0
// =============================================================================
module tb_univ_shift_reg;

  logic       clk;
  logic       reset;
  logic       en;
  logic       start;
  logic [2:0] op;
  logic [7:0] d;
  logic [3:0] amt;
  logic       sin;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  int n_checks;
  int n_pass;
  int m_q;
  int m_sout;

  univ_shift_reg #(.WIDTH(8), .AMT_W(4), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .start (start),
    .op    (op),
    .d     (d),
    .amt   (amt),
    .sin   (sin),
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: register value treated as an unsigned integer 0..255.
  task automatic m_apply(input int o, input int dv, input int s);
    int v;
    v = m_q;
    case (o)
      1: m_q = dv;
      2: begin m_sout = v / 128; m_q = (v * 2) % 256 + s; end
      3: begin m_sout = v % 2;   m_q = v / 2 + s * 128; end
      4: begin m_sout = v / 128; m_q = (v * 2) % 256 + v / 128; end
      5: begin m_sout = v % 2;   m_q = v / 2 + (v % 2) * 128; end
      6: begin m_sout = v % 2;   m_q = v / 2 + ((v >= 128) ? 128 : 0); end
      7: m_q = 0;
      default: ;
    endcase
  endtask

  task automatic load_val(input logic [7:0] v);
    en = 1'b1; start = 1'b0; op = 3'd1; d = v;
    tick();
    m_q = v;
    op = 3'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; op = 3'd1; d = 8'hA5; start = 1'b0; amt = 4'd0; sin = 1'b0;
    #1;
    n_checks++;
    if ({q, sout, busy, done} !== 11'h000) $display("FAIL reset_async: got %h exp 000", {q, sout, busy, done});
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({q, sout, busy, done} !== 11'h000) $display("FAIL reset_hold: got %h exp 000", {q, sout, busy, done});
      else n_pass++;
    end
    @(negedge clk) reset = 1'b1;
    tick();
    n_checks++;
    if ({q, sout, busy, done} !== {8'hA5, 3'b000}) $display("FAIL reset_release_load: got %h exp %h", {q, sout, busy, done}, {8'hA5, 3'b000});
    else n_pass++;
    m_q = 8'hA5; m_sout = 0;
  endtask

  task automatic test_enable();
    en = 1'b0; op = 3'd7;
    tick();
    n_checks++;
    if (q !== 8'hA5) $display("FAIL enable_freeze: got %h exp a5", q);
    else n_pass++;
    en = 1'b1; op = 3'd1; d = 8'h3C;
    tick();
    n_checks++;
    if (q !== 8'h3C) $display("FAIL enable_load: got %h exp 3c", q);
    else n_pass++;
    m_q = 8'h3C;
  endtask

  task automatic test_single_ops();
    logic [2:0] ops [6];
    logic [7:0] exq [6];
    ops = '{3'd4, 3'd5, 3'd6, 3'd3, 3'd2, 3'd7};
    exq = '{8'h4B, 8'hD2, 8'hD2, 8'h52, 8'h4A, 8'h00};
    for (int i = 0; i < 6; i++) begin
      load_val(8'hA5);
      op = ops[i]; sin = 1'b0;
      tick();
      // Every shift from A5 ejects a 1, and CLEAR keeps the previous sout of 1.
      n_checks++;
      if ({q, sout, busy, done} !== {exq[i], 3'b100})
        $display("FAIL single_op%0d: got %h exp %h", ops[i], {q, sout, busy, done}, {exq[i], 3'b100});
      else n_pass++;
      m_q = exq[i]; m_sout = 1;
    end
    op = 3'd0;
  endtask

  task automatic test_random_single();
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); d = 8'($urandom); sin = 1'($urandom);
      en = ($urandom_range(0, 3) != 0); start = 1'b0;
      if (en) m_apply(int'(op), int'(d), int'(sin));
      tick();
      n_checks++;
      if ({q, sout, busy, done} !== {m_q[7:0], m_sout[0], 2'b00})
        $display("FAIL rand_single op=%0d en=%0d: got %h exp %h", op, en, {q, sout, busy, done}, {m_q[7:0], m_sout[0], 2'b00});
      else n_pass++;
    end
    en = 1'b1; op = 3'd0;
  endtask

  task automatic test_start_degenerate();
    load_val(8'h5A);
    start = 1'b1; op = 3'd1; d = 8'h77;
    tick();
    n_checks++;
    if ({q, busy, done} !== {8'h77, 2'b01}) $display("FAIL start_load: got %h exp %h", {q, busy, done}, {8'h77, 2'b01});
    else n_pass++;
    op = 3'd3; amt = 4'd0;
    tick();
    n_checks++;
    if ({q, busy, done} !== {8'h77, 2'b01}) $display("FAIL start_amt0: got %h exp %h", {q, busy, done}, {8'h77, 2'b01});
    else n_pass++;
    start = 1'b0; op = 3'd0;
    tick();
    n_checks++;
    if ({q, busy, done} !== {8'h77, 2'b00}) $display("FAIL done_clears: got %h exp %h", {q, busy, done}, {8'h77, 2'b00});
    else n_pass++;
    m_q = 8'h77;
  endtask

  task automatic test_seq_ror();
    load_val(8'h81);
    start = 1'b1; op = 3'd5; amt = 4'd3;
    tick();
    n_checks++;
    if ({q, sout, busy, done} !== {8'hC0, 3'b110}) $display("FAIL seq_ror_s1: got %h exp %h", {q, sout, busy, done}, {8'hC0, 3'b110});
    else n_pass++;
    op = 3'd1; d = 8'hFF;
    tick();
    n_checks++;
    if ({q, sout, busy, done} !== {8'h60, 3'b010}) $display("FAIL seq_ror_s2: got %h exp %h", {q, sout, busy, done}, {8'h60, 3'b010});
    else n_pass++;
    start = 1'b0; op = 3'd0;
    tick();
    n_checks++;
    if ({q, sout, busy, done} !== {8'h30, 3'b001}) $display("FAIL seq_ror_done: got %h exp %h", {q, sout, busy, done}, {8'h30, 3'b001});
    else n_pass++;
    tick();
    n_checks++;
    if ({q, sout, busy, done} !== {8'h30, 3'b000}) $display("FAIL seq_ror_after: got %h exp %h", {q, sout, busy, done}, {8'h30, 3'b000});
    else n_pass++;
    m_q = 8'h30; m_sout = 0;
  endtask

  task automatic test_stall();
    logic [7:0] exq [4];
    logic [1:0] exbd [4];
    logic       ens [4];
    exq  = '{8'h06, 8'h06, 8'h06, 8'h0C};
    exbd = '{2'b10, 2'b10, 2'b10, 2'b01};
    ens  = '{1'b1, 1'b0, 1'b0, 1'b1};
    load_val(8'h03);
    start = 1'b1; op = 3'd2; amt = 4'd2; sin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = ens[i];
      tick();
      start = 1'b0;
      n_checks++;
      if ({q, busy, done} !== {exq[i], exbd[i]}) $display("FAIL stall_c%0d: got %h exp %h", i, {q, busy, done}, {exq[i], exbd[i]});
      else n_pass++;
    end
    en = 1'b1; op = 3'd0;
    tick();
    m_q = 8'h0C; m_sout = 0;
  endtask

  task automatic test_reset_mid();
    load_val(8'h01);
    start = 1'b1; op = 3'd4; amt = 4'd5;
    tick();
    start = 1'b0;
    tick();
    n_checks++;
    if ({q, busy} !== {8'h04, 1'b1}) $display("FAIL mid_pre_reset: got %h exp %h", {q, busy}, {8'h04, 1'b1});
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({q, sout, busy, done} !== 11'h000) $display("FAIL mid_reset_async: got %h exp 000", {q, sout, busy, done});
    else n_pass++;
    @(negedge clk) reset = 1'b1;
    op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({q, busy, done} !== 10'h000) $display("FAIL mid_no_done: got %h exp 000", {q, busy, done});
      else n_pass++;
    end
    start = 1'b1; op = 3'd2; amt = 4'd1; sin = 1'b1;
    tick();
    start = 1'b0; op = 3'd0;
    n_checks++;
    if ({q, sout, busy, done} !== {8'h01, 3'b001}) $display("FAIL mid_restart: got %h exp %h", {q, sout, busy, done}, {8'h01, 3'b001});
    else n_pass++;
    m_q = 1; m_sout = 0;
  endtask

  task automatic test_random_seq();
    int o, n, rem, guard;
    for (int t = 0; t < 12; t++) begin
      load_val(8'($urandom));
      o = $urandom_range(2, 6);
      n = $urandom_range(0, 15);
      en = 1'b1; start = 1'b1; op = 3'(o); amt = 4'(n); sin = 1'($urandom);
      if (n > 0) m_apply(o, 0, int'(sin));
      rem = (n > 0) ? n - 1 : 0;
      tick();
      n_checks++;
      if ({q, sout, busy, done} !== {m_q[7:0], m_sout[0], (rem > 0), (rem == 0)})
        $display("FAIL rand_seq_start op=%0d amt=%0d: got %h exp %h", o, n, {q, sout, busy, done}, {m_q[7:0], m_sout[0], (rem > 0), (rem == 0)});
      else n_pass++;
      guard = 0;
      while (rem > 0 && guard < 200) begin
        guard++;
        en = ($urandom_range(0, 3) != 0); sin = 1'($urandom);
        start = 1'($urandom); op = 3'($urandom); d = 8'($urandom); amt = 4'($urandom);
        if (en) begin
          m_apply(o, 0, int'(sin));
          rem--;
        end
        tick();
        n_checks++;
        if ({q, sout, busy, done} !== {m_q[7:0], m_sout[0], (rem > 0), (en && rem == 0)})
          $display("FAIL rand_seq_step op=%0d rem=%0d: got %h exp %h", o, rem, {q, sout, busy, done}, {m_q[7:0], m_sout[0], (rem > 0), (en && rem == 0)});
        else n_pass++;
      end
      en = 1'b1; start = 1'b0; op = 3'd0;
      tick();
      n_checks++;
      if ({q, busy, done} !== {m_q[7:0], 2'b00}) $display("FAIL rand_seq_idle: got %h exp %h", {q, busy, done}, {m_q[7:0], 2'b00});
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; m_q = 0; m_sout = 0;
    test_reset();
    test_enable();
    test_single_ops();
    test_random_single();
    test_start_degenerate();
    test_seq_ror();
    test_stall();
    test_reset_mid();
    test_random_seq();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register that generalises the single-bit enabled D flip-flop to WIDTH bits with eight operating modes. It supports single-cycle ops (hold, load, shifts, rotates, arithmetic shift, clear) and a sequenced multi-step shift, one step per enabled cycle, with a busy/done handshake. It is the standard data register and serial/parallel converter for the sequential design modules library.

Parameters:
WIDTH, 8, register width in bits (>=2)
AMT_W, 4, width of the multi-step shift amount (max amt = 2^AMT_W-1)
RESET_VAL, 0, value loaded into q on reset (WIDTH bits)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low; reset=0 clears state immediately
en  input  1  clock enable; en=0 freezes q, sout and the step counter
start  input  1  request a sequenced operation (sampled only when idle and en=1)
op  input  3  000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLEAR
d  input  WIDTH  parallel load data
amt  input  AMT_W  number of shift steps for a sequenced op
sin  input  1  serial input: enters LSB on SHL, MSB on SHR
q  output  WIDTH  register contents
sout  output  1  registered: last bit shifted or rotated out
busy  output  1  high while a sequenced shift is in progress
done  output  1  one-cycle pulse after a sequenced op completes

Behaviour:
- Reset (reset=0, asynchronous): q=RESET_VAL, sout=0, busy=0, done=0, FSM=IDLE, counter=0. Reset overrides en, start and any op in progress.
- States: IDLE and SHIFT. done is a registered flag and does not need its own state.
- IDLE, en=1, start=0: apply op once at the clock edge.
  - HOLD: q unchanged.
  - LOAD: q=d.
  - SHL: q={q[W-2:0],sin}, sout=q[W-1].
  - SHR: q={sin,q[W-1:1]}, sout=q[0].
  - ROL: q={q[W-2:0],q[W-1]}, sout=q[W-1].
  - ROR: q={q[0],q[W-1:1]}, sout=q[0].
  - ASR: q={q[W-1],q[W-1:1]}, sout=q[0].
  - CLEAR: q=0.
  - done stays 0.
- sout changes only on shift and rotate ops. HOLD, LOAD and CLEAR keep sout unchanged.
- IDLE, en=1, start=1, op in SHL..ASR, amt>0:
  - Latch op and amt.
  - Apply the first step at the same edge.
  - If amt=1: stay IDLE and set done=1 at that edge.
  - Otherwise: go to SHIFT, counter=amt-1, busy=1 from that edge.
- IDLE, en=1, start=1, with op in HOLD/LOAD/CLEAR or amt=0: execute op once (HOLD if shift op with amt=0); done=1 for the next cycle.
- SHIFT, en=1: apply the latched op and decrement counter. On the edge where the counter goes 1->0: busy=0, FSM=IDLE, done=1 for one cycle.
- SHIFT, en=0: stall. q, counter and busy are held.
- Live op, d, start and amt are ignored in SHIFT. sin is sampled live on every step.
- done clears on the next clock edge regardless of en.
- amt may exceed WIDTH: keep shifting; q becomes fully sin-filled (SHL/SHR), sign-filled (ASR) or wraps (ROL/ROR).
- IDLE, en=0: nothing changes, including start, which is dropped.
- Latency: a single-cycle op is visible in q after 1 edge. A sequenced op of amt=N with en held high sets busy for N-1 cycles; done is high in cycle N+1 after start.

Test Plan:
- Reset: reset=0 with en=1, op=LOAD, d=8'hA5 -> q=00, sout=0, busy=0, done=0 throughout. Release -> next edge loads A5.
- Enable gating: q=A5, en=0, op=CLEAR -> q stays A5. Then en=1, op=LOAD, d=3C -> q=3C after 1 edge.
- Single-cycle ops from q=A5:
  - ROL -> 4B, sout=1.
  - ROR (from A5) -> D2, sout=1.
  - ASR (from A5) -> D2.
  - SHR sin=0 (from A5) -> 52.
  - SHL sin=0 (from A5) -> 4A.
  - CLEAR -> 00.
- Sequenced ROR: q=81, start, amt=3 -> q steps C0, 60, 30 on successive edges. busy high 2 cycles, then done=1 for exactly 1 cycle, sout=0. A start pulse while busy has no effect.
- Stall: q=03, start, op=SHL, amt=2, sin=0; en=0 for 2 cycles after the first step -> q 06, held 06, 06, then 0C. busy high 3 cycles, then done pulse.
- Reset mid-op: q=01, start, op=ROL, amt=5; assert reset after 2 steps (q=04) -> q=00, busy=0 immediately, and no done pulse. After release, FSM is IDLE and accepts a new start.
